// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared serial types and constants for the receive and transmit paths
package serial_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DATA_W               = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Even parity: data bits plus the parity bit must XOR to zero.
  function automatic logic even_parity_ok(input logic [DATA_W-1:0] d, input logic p);
    return ~(^{d, p});
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser for asynchronous board inputs, resets to 1
module sync2 (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/serial_recv.sv
// rtl/serial_recv.sv - UART receiver (8N1, or 8E1 with SERIAL_RECV_PARITY_EN) with one-entry holding register
module serial_recv
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rxd,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              frame_err,
  output logic              overrun
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  logic              w_rxs;
  logic              w_tick;
  logic              w_accept;
  logic              w_stop_ok;

  rx_state_t         r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_idx;
  logic [DATA_W-1:0] r_shift;

  sync2 u_sync (
    .i_clk    (clk),
    .i_resetn (reset),
    .i_d      (rxd),
    .o_q      (w_rxs)
  );

  assign w_tick   = (r_cnt == '0);
  assign w_accept = valid && ready;

`ifdef SERIAL_RECV_PARITY_EN
  logic r_par;
  assign w_stop_ok = w_rxs && even_parity_ok(r_shift, r_par);
`else
  assign w_stop_ok = w_rxs;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef SERIAL_RECV_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      if (w_accept) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
      if (r_state != IDLE && r_state != WAIT_IDLE && !w_tick)
        r_cnt <= r_cnt - 1'b1;

      case (r_state)
        IDLE: begin
          if (!w_rxs) begin
            r_cnt   <= HALF_LOAD;
            r_state <= START;
          end
        end
        START: begin
          if (w_tick) begin
            if (!w_rxs) begin
              r_state <= DATA;
              r_cnt   <= FULL_LOAD;
              r_idx   <= '0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift <= {w_rxs, r_shift[DATA_W-1:1]};
            r_cnt   <= FULL_LOAD;
            r_idx   <= r_idx + 1'b1;
            if (r_idx == 3'd7) begin
`ifdef SERIAL_RECV_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end
        end
`ifdef SERIAL_RECV_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_par   <= w_rxs;
            r_cnt   <= FULL_LOAD;
            r_state <= STOP;
          end
        end
`endif
        STOP: begin
          // Leaving at mid-stop lets the next start edge be caught on time.
          if (w_tick) begin
            if (w_stop_ok) begin
              r_state <= IDLE;
              if (!valid || ready) begin
                data  <= r_shift;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              r_state   <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (w_rxs)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
